capture_sequencer: RTL
======================

Name: capture_sequencer

Overview:
Controller for the 1-bit-sampled capture path. It owns the write/read addressing of the external 2^AW x 16 sample RAM: arm, circular pre-trigger fill, post-trigger count, then a read-out dump that streams words as bytes through the acia_tx byte handshake. The block sits between the 16-bit shift-packer strobe, the SB_RAM40_4K instance and the UART transmitter, and replaces ad-hoc sequencing logic.

Parameters:
AW, 8, RAM address width; buffer depth 2^AW words.
DW, 16, RAM word width; fixed at 16 (two bytes per word).
POST_CNT, 128, words written after trigger before capture stops; legal range 1..2^AW-1.
HDR_BYTE, 8'hA5, sync byte sent before each dump.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
arm  in  1  one-cycle pulse: start a capture
abort  in  1  level: return to IDLE
trig  in  1  trigger event (sampled level)
wr_stb  in  1  new packed word valid this cycle
ram_we  out  1  RAM write enable
ram_waddr  out  AW  RAM write address
ram_raddr  out  AW  RAM read address
ram_rdata  in  DW  RAM read data, valid 1 cycle after ram_raddr
tx_dat  out  8  byte to UART
tx_start  out  1  one-cycle UART start pulse
tx_busy  in  1  UART busy
state_o  out  3  current state encoding
done  out  1  high in DONE

Behaviour:
- Reset: state IDLE, ram_we=0, ram_waddr=0, ram_raddr=0, tx_start=0, tx_dat=0, done=0, internal counters 0.
- States: IDLE=0, ARMED=1, POST=2, HDR=3, RD=4, LO=5, HI=6, DONE=7.
- IDLE: arm -> ARMED. ram_waddr is not reset on arm.
- ARMED: ram_we=wr_stb. ram_waddr increments (mod 2^AW) each written word. trig high -> POST, post counter cleared. A trig in the same cycle as arm is ignored. A trig in IDLE is ignored.
- POST: ram_we=wr_stb. Each write increments the post counter. The write that makes the count equal POST_CNT is performed, then -> HDR. start_addr <= ram_waddr+1, which is the oldest word, mod 2^AW.
- ram_we is combinational: wr_stb & (ARMED|POST). It is never asserted in any other state.
- HDR: when !tx_busy and the guard is clear, tx_dat=HDR_BYTE, tx_start=1 -> RD. ram_raddr=start_addr. Word counter is 0.
- Byte handshake:
  - A byte is accepted on its tx_start cycle.
  - The next tx_start may not come earlier than 2 cycles later. The guard cycle masks the late rise of tx_busy.
  - After the guard, the next tx_start waits for tx_busy low.
- RD: one-cycle read latency. Wait 1 cycle, then -> LO.
- LO: send ram_rdata[7:0] -> HI.
- HI: send ram_rdata[15:8]. The data is held stable because ram_raddr is unchanged.
  - If word counter = 2^AW-1 -> DONE.
  - Otherwise ram_raddr+1 (wraps), word counter+1 -> RD.
- Dump order: oldest to newest, all 2^AW words, low byte first. Total 1 + 2^(AW+1) bytes.
- DONE: done=1. arm -> ARMED (new capture, done cleared). Otherwise it holds.
- abort:
  - Any state -> IDLE at the next edge and has priority over all other inputs.
  - A tx_start pulse that has already been issued is not retracted.
  - tx_start is 0 from the abort edge onward.
- rst mid-operation gives the reset values; a partial dump is not resumed.
- arm in ARMED, POST or dump states is ignored.
- wr_stb is ignored outside ARMED and POST, and the RAM contents are preserved during the dump.

Optional Feature:
PRETRIG_FILL_EN.
- Defined: in ARMED, trig is ignored until at least 2^AW-POST_CNT words have been written since arm. This uses a fill counter saturating at 2^AW-POST_CNT, and guarantees that every dumped word is from the current capture.
- Undefined: trig is accepted on any ARMED cycle; the dump may contain stale words from before arm. The fill counter is not built.

Test Plan:
- Reset, arm, wr_stb every 16 cycles with data = write index, trig after 200 words -> exactly 128 further writes, ram_we never asserts afterwards, state HDR, start_addr = (200+128) mod 256 = 72.
- Full dump with a tx_busy model (busy 10 cycles after each start) -> 513 tx_start pulses: first 0xA5, then bytes of words 72..255,0..71, low byte first; done=1 afterwards.
- trig asserted in IDLE and in the same cycle as arm -> stays ARMED, no post counting.
- abort asserted during POST and again mid-dump after 37 bytes -> IDLE next cycle, ram_we=0, no further tx_start; a subsequent arm captures normally.
- rst asserted in HI state -> all outputs at reset values next cycle; state_o=0.
- PRETRIG_FILL_EN defined, trig after 50 words -> ignored. Trig held until word 128 -> accepted at 128; the 128 post words end at word 256, start_addr=0.

Source files
------------

// File: rtl/capture_sequencer.sv
// Capture path sequencer: sample RAM addressing (arm, circular pre-trigger fill, post-trigger count)
// and a header + word dump over the UART byte handshake. Optional feature macro: PRETRIG_FILL_EN.
module capture_sequencer #(
  parameter int         AW       = 8,
  parameter int         DW       = 16,
  parameter int         POST_CNT = 128,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig,
  input  logic          wr_stb,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic [7:0]    tx_dat,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic [2:0]    state_o,
  output logic          done
);

  // state | meaning
  // IDLE  | waiting for arm
  // ARMED | circular pre-trigger fill, waiting for trig
  // POST  | writing POST_CNT words after the trigger
  // HDR   | send sync byte
  // RD    | RAM read latency slot
  // LO    | send low byte of current word
  // HI    | send high byte, advance read address
  // DONE  | dump complete, waiting for re-arm
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_HDR   = 3'd3,
    S_RD    = 3'd4,
    S_LO    = 3'd5,
    S_HI    = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [AW-1:0] POST_LAST = AW'(POST_CNT - 1);
  localparam logic [AW-1:0] WORD_LAST = '1;

  state_t        state, state_nxt;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] word_cnt;
  logic [AW-1:0] start_addr;
  logic          send;
  logic [7:0]    send_byte;
  logic          tx_ok;
  logic          trig_ok;

`ifdef PRETRIG_FILL_EN
  localparam logic [AW-1:0] FILL_TGT = AW'((1 << AW) - POST_CNT);
  logic [AW-1:0] fill_cnt;

  assign trig_ok = (fill_cnt == FILL_TGT);

  // Cleared outside ARMED, so every arm starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst)                                fill_cnt <= '0;
    else if (state != S_ARMED)              fill_cnt <= '0;
    else if (ram_we && fill_cnt != FILL_TGT) fill_cnt <= fill_cnt + AW'(1);
  end
`else
  assign trig_ok = 1'b1;
`endif

  assign ram_we  = wr_stb && (state == S_ARMED || state == S_POST);
  // The cycle tx_start is high is the guard slot: the UART's busy has not risen yet.
  assign tx_ok   = !tx_busy && !tx_start;
  assign done    = (state == S_DONE);
  assign state_o = state;

  always_comb begin
    state_nxt = state;
    send      = 1'b0;
    send_byte = 8'h00;
    case (state)
      S_IDLE:  if (arm) state_nxt = S_ARMED;
      S_ARMED: if (trig && trig_ok) state_nxt = S_POST;
      S_POST:  if (ram_we && post_cnt == POST_LAST) state_nxt = S_HDR;
      S_HDR: begin
        if (tx_ok) begin
          send      = 1'b1;
          send_byte = HDR_BYTE;
          state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = S_LO;
      S_LO: begin
        if (tx_ok) begin
          send      = 1'b1;
          send_byte = ram_rdata[7:0];
          state_nxt = S_HI;
        end
      end
      S_HI: begin
        if (tx_ok) begin
          send      = 1'b1;
          send_byte = ram_rdata[15:8];
          state_nxt = (word_cnt == WORD_LAST) ? S_DONE : S_RD;
        end
      end
      S_DONE:  if (arm) state_nxt = S_ARMED;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      send      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ram_waddr  <= '0;
      ram_raddr  <= '0;
      start_addr <= '0;
      post_cnt   <= '0;
      word_cnt   <= '0;
      tx_start   <= 1'b0;
      tx_dat     <= 8'h00;
    end else begin
      state    <= state_nxt;
      tx_start <= send;
      if (send) tx_dat <= send_byte;
      if (ram_we) ram_waddr <= ram_waddr + AW'(1);
      if (state == S_ARMED)              post_cnt <= '0;
      else if (state == S_POST && ram_we) post_cnt <= post_cnt + AW'(1);
      // Oldest word sits just past the final post-trigger write.
      if (state == S_POST && state_nxt == S_HDR) start_addr <= ram_waddr + AW'(1);
      if (state == S_HDR) begin
        ram_raddr <= start_addr;
        word_cnt  <= '0;
      end else if (state == S_HI && send) begin
        ram_raddr <= ram_raddr + AW'(1);
        word_cnt  <= word_cnt + AW'(1);
      end
    end
  end

endmodule
